// File: rtl/pc_arb_pkg.sv
// rtl/pc_arb_pkg.sv - shared constants, state type and helpers for the N/K/M stream arbiter
//
// Contents:
//   SEL_N / SEL_K / SEL_M / SEL_NONE : one-hot grant and source encodings
//   BURST_LEN_DEFAULT                : default maximum beats per grant
//   arb_state_t                      : arbiter state {IDLE, GRANT}
//   rot_next()                       : one-hot rotate to the next requester (N->K->M->N)

package pc_arb_pkg;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_N    = 3'b001;
   localparam logic [2:0] SEL_K    = 3'b010;
   localparam logic [2:0] SEL_M    = 3'b100;

   localparam int BURST_LEN_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [2:0] rot_next(input logic [2:0] sel);
      return {sel[1:0], sel[2]};
   endfunction

endpackage

// File: rtl/pc_mux3_onehot.sv
// rtl/pc_mux3_onehot.sv - 3-to-1 one-hot data mux for the shared pointcloud datapath
//
// Ports:
//   sel  in  3  one-hot select {d2, d1, d0}
//   d0   in  W  input selected by sel[0]
//   d1   in  W  input selected by sel[1]
//   d2   in  W  input selected by sel[2]
//   y    out W  selected data; all zeros when sel is 000

module pc_mux3_onehot #(
   parameter int W = 8
) (
   input  logic [2:0]   sel,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   output logic [W-1:0] y
);

   assign y = ({W{sel[0]}} & d0) | ({W{sel[1]}} & d1) | ({W{sel[2]}} & d2);

endmodule

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational rotating-priority picker over three requesters
//
// Ports:
//   req  in  3  request vector {M, K, N}
//   ptr  in  3  one-hot priority pointer; the requester it names is tried first
//   win  out 3  one-hot winner, SEL_NONE when no request is set

module rr_pick3
   import pc_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] win
);

   always_comb begin
      win = SEL_NONE;
      case (ptr)
         SEL_K: begin
            if (req[1])      win = SEL_K;
            else if (req[2]) win = SEL_M;
            else if (req[0]) win = SEL_N;
         end
         SEL_M: begin
            if (req[2])      win = SEL_M;
            else if (req[0]) win = SEL_N;
            else if (req[1]) win = SEL_K;
         end
         default: begin
            if (req[0])      win = SEL_N;
            else if (req[1]) win = SEL_K;
            else if (req[2]) win = SEL_M;
         end
      endcase
   end

endmodule

// File: rtl/nkm_stream_arbiter.sv
// rtl/nkm_stream_arbiter.sv - round-robin burst arbiter sharing one datapath between streams N, K, M
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   n/k/m_valid, n/k/m_data     producer beats
//   n/k/m_ready                 beat accepted this cycle (combinational)
//   grant_sel                   one-hot mux select, 000 when no stream is granted
//   out_valid, out_data         single-stage output register toward the downstream stage
//   out_src                     one-hot source tag of the beat in out_data
//   out_ready                   downstream accepts the output beat
//   busy                        high while a stream is granted

module nkm_stream_arbiter
   import pc_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              n_valid,
   input  logic [DATA_W-1:0] n_data,
   output logic              n_ready,
   input  logic              k_valid,
   input  logic [DATA_W-1:0] k_data,
   output logic              k_ready,
   input  logic              m_valid,
   input  logic [DATA_W-1:0] m_data,
   output logic              m_ready,
   output logic [2:0]        grant_sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        out_src,
   input  logic              out_ready,
   output logic              busy
);

   localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);

   arb_state_t        state, state_nx;
   logic [2:0]        grant_nx;
   logic [2:0]        ptr, ptr_nx;
   logic [7:0]        count, count_nx;
   logic              out_valid_nx;
   logic [DATA_W-1:0] out_data_nx;
   logic [2:0]        out_src_nx;

   logic [2:0]        valid_vec;
   logic [2:0]        winner;
   logic [2:0]        ready_vec;
   logic [DATA_W-1:0] mux_y;
   logic              slot_free;
   logic              granted_valid;
   logic              accept;
   logic              last_beat;

   assign valid_vec     = {m_valid, k_valid, n_valid};
   assign slot_free     = !out_valid || out_ready;
   assign granted_valid = |(grant_sel & valid_vec);
   assign ready_vec     = (state == GRANT && slot_free) ? grant_sel : SEL_NONE;
   assign n_ready       = ready_vec[0];
   assign k_ready       = ready_vec[1];
   assign m_ready       = ready_vec[2];
   assign accept        = (state == GRANT) && granted_valid && slot_free;
   assign last_beat     = (count + 8'd1) == BURST_LAST;

   rr_pick3 u_pick (
      .req (valid_vec),
      .ptr (ptr),
      .win (winner)
   );

   pc_mux3_onehot #(.W(DATA_W)) u_mux (
      .sel (grant_sel),
      .d0  (n_data),
      .d1  (k_data),
      .d2  (m_data),
      .y   (mux_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_sel <= SEL_NONE;
         ptr       <= SEL_N;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= SEL_NONE;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         grant_sel <= grant_nx;
         ptr       <= ptr_nx;
         count     <= count_nx;
         out_valid <= out_valid_nx;
         out_data  <= out_data_nx;
         out_src   <= out_src_nx;
         busy      <= (state_nx == GRANT);
      end
   end

   always_comb begin
      state_nx     = state;
      grant_nx     = grant_sel;
      ptr_nx       = ptr;
      count_nx     = count;
      out_valid_nx = out_valid;
      out_data_nx  = out_data;
      out_src_nx   = out_src;

      case (state)
         IDLE: begin
            if (|valid_vec) begin
               state_nx = GRANT;
               grant_nx = winner;
               count_nx = '0;
               // pointer moves only on a grant, to the stream after the winner
               ptr_nx   = rot_next(winner);
            end else begin
               grant_nx = SEL_NONE;
            end
         end
         GRANT: begin
            if (!granted_valid) begin
               // a gap from the granted producer ends its burst
               state_nx = IDLE;
               grant_nx = SEL_NONE;
            end else if (accept) begin
               count_nx = count + 8'd1;
               if (last_beat) begin
                  state_nx = IDLE;
                  grant_nx = SEL_NONE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = SEL_NONE;
         end
      endcase

      // accept implies a live grant, so the mux output is always defined on load
      if (accept) begin
         out_valid_nx = 1'b1;
         out_data_nx  = mux_y;
         out_src_nx   = grant_sel;
      end else if (out_ready) begin
         out_valid_nx = 1'b0;
      end
   end

endmodule

// File: tb/tb_nkm_stream_arbiter.sv
// tb/tb_nkm_stream_arbiter.sv - directed self-checking bench for nkm_stream_arbiter

module tb_nkm_stream_arbiter;

   logic       clk = 1'b0;
   logic       rst;

   logic       n_valid, k_valid, m_valid;
   logic [7:0] n_data, k_data, m_data;
   logic       n_ready, k_ready, m_ready;
   logic [2:0] grant_sel;
   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] out_src;
   logic       out_ready;
   logic       busy;

   logic       b1_n_valid, b1_k_valid, b1_m_valid;
   logic [7:0] b1_n_data, b1_k_data, b1_m_data;
   logic       b1_n_ready, b1_k_ready, b1_m_ready;
   logic [2:0] b1_grant_sel;
   logic       b1_out_valid;
   logic [7:0] b1_out_data;
   logic [2:0] b1_out_src;
   logic       b1_out_ready;
   logic       b1_busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nkm_stream_arbiter #(.DATA_W(8), .BURST_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .n_valid   (n_valid),
      .n_data    (n_data),
      .n_ready   (n_ready),
      .k_valid   (k_valid),
      .k_data    (k_data),
      .k_ready   (k_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .grant_sel (grant_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .busy      (busy)
   );

   nkm_stream_arbiter #(.DATA_W(8), .BURST_LEN(1)) dut_b1 (
      .clk       (clk),
      .rst       (rst),
      .n_valid   (b1_n_valid),
      .n_data    (b1_n_data),
      .n_ready   (b1_n_ready),
      .k_valid   (b1_k_valid),
      .k_data    (b1_k_data),
      .k_ready   (b1_k_ready),
      .m_valid   (b1_m_valid),
      .m_data    (b1_m_data),
      .m_ready   (b1_m_ready),
      .grant_sel (b1_grant_sel),
      .out_valid (b1_out_valid),
      .out_data  (b1_out_data),
      .out_src   (b1_out_src),
      .out_ready (b1_out_ready),
      .busy      (b1_busy)
   );

   task automatic clear_inputs();
      n_valid = 0; k_valid = 0; m_valid = 0;
      n_data = 8'h00; k_data = 8'h00; m_data = 8'h00;
      out_ready = 0;
      b1_n_valid = 0; b1_k_valid = 0; b1_m_valid = 0;
      b1_n_data = 8'h00; b1_k_data = 8'h00; b1_m_data = 8'h00;
      b1_out_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      n_valid = 1; k_valid = 1; m_valid = 1; out_ready = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (grant_sel !== 3'b000) begin errors++; $display("FAIL reset grant_sel: got %b expected 000", grant_sel); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h expected 00", out_data); end
      checks++;
      if (out_src !== 3'b000) begin errors++; $display("FAIL reset out_src: got %b expected 000", out_src); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      checks++;
      if ({m_ready, k_ready, n_ready} !== 3'b000) begin errors++; $display("FAIL reset readies: got %b expected 000", {m_ready, k_ready, n_ready}); end
      checks++;
      if (b1_grant_sel !== 3'b000) begin errors++; $display("FAIL reset b1 grant_sel: got %b expected 000", b1_grant_sel); end
      rst = 0;
      clear_inputs();
   endtask

   task automatic test_single_n();
      logic [2:0] exp_g [6];
      logic       prev_acc;
      exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
      do_reset();
      n_valid = 1; n_data = 8'h10; out_ready = 1;
      prev_acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (prev_acc) n_data = n_data + 8'h01;
         #1;
         checks++;
         if (grant_sel !== exp_g[i]) begin errors++; $display("FAIL single_n grant[%0d]: got %b expected %b", i, grant_sel, exp_g[i]); end
         checks++;
         if (busy !== (exp_g[i] != 3'b000)) begin errors++; $display("FAIL single_n busy[%0d]: got %b expected %b", i, busy, exp_g[i] != 3'b000); end
         if (i >= 1 && i <= 4) begin
            checks++;
            if (out_data !== 8'(8'h10 + i - 1)) begin errors++; $display("FAIL single_n data[%0d]: got %h expected %h", i, out_data, 8'(8'h10 + i - 1)); end
            checks++;
            if (out_src !== 3'b001 || out_valid !== 1'b1) begin errors++; $display("FAIL single_n src[%0d]: got src=%b valid=%b expected src=001 valid=1", i, out_src, out_valid); end
         end
         prev_acc = n_valid && n_ready;
      end
      n_valid = 0;
   endtask

   task automatic test_contention();
      int         cnt_n, cnt_k, cnt_m, r;
      logic [2:0] exp_g;
      do_reset();
      n_valid = 1; k_valid = 1; m_valid = 1;
      n_data = 8'hA1; k_data = 8'hB2; m_data = 8'hC3; out_ready = 1;
      cnt_n = 0; cnt_k = 0; cnt_m = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         r = i % 15;
         if (r % 5 == 4)      exp_g = 3'b000;
         else if (r / 5 == 0) exp_g = 3'b001;
         else if (r / 5 == 1) exp_g = 3'b010;
         else                 exp_g = 3'b100;
         checks++;
         if (grant_sel !== exp_g) begin errors++; $display("FAIL contention grant[%0d]: got %b expected %b", i, grant_sel, exp_g); end
         if (n_valid && n_ready) cnt_n++;
         if (k_valid && k_ready) cnt_k++;
         if (m_valid && m_ready) cnt_m++;
      end
      checks++;
      if (cnt_n != 16) begin errors++; $display("FAIL contention n_beats: got %0d expected 16", cnt_n); end
      checks++;
      if (cnt_k != 16) begin errors++; $display("FAIL contention k_beats: got %0d expected 16", cnt_k); end
      checks++;
      if (cnt_m != 16) begin errors++; $display("FAIL contention m_beats: got %0d expected 16", cnt_m); end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      logic or_tab [10];
      logic exp_rdy [10];
      logic prev_acc;
      int   beats;
      or_tab  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      exp_rdy = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      do_reset();
      k_valid = 1; k_data = 8'h20; out_ready = 1;
      prev_acc = 0; beats = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (prev_acc) k_data = k_data + 8'h01;
         out_ready = or_tab[i];
         #1;
         checks++;
         if (k_ready !== exp_rdy[i]) begin errors++; $display("FAIL backpressure k_ready[%0d]: got %b expected %b", i, k_ready, exp_rdy[i]); end
         if (i >= 1 && i <= 5) begin
            checks++;
            if (out_data !== 8'h20 || out_src !== 3'b010 || out_valid !== 1'b1 || grant_sel !== 3'b010)
            begin
               errors++;
               $display("FAIL backpressure hold[%0d]: got data=%h src=%b valid=%b grant=%b expected data=20 src=010 valid=1 grant=010",
                        i, out_data, out_src, out_valid, grant_sel);
            end
         end
         if (k_valid && k_ready) beats++;
         prev_acc = k_valid && k_ready;
      end
      checks++;
      if (grant_sel !== 3'b000) begin errors++; $display("FAIL backpressure release grant: got %b expected 000", grant_sel); end
      checks++;
      if (out_data !== 8'h23) begin errors++; $display("FAIL backpressure last data: got %h expected 23", out_data); end
      checks++;
      if (beats != 4) begin errors++; $display("FAIL backpressure beats: got %0d expected 4", beats); end
      clear_inputs();
   endtask

   task automatic test_gap_release();
      logic       mv_tab [5];
      logic       nk_tab [5];
      logic [2:0] exp_g [5];
      logic       prev_acc;
      int         beats;
      mv_tab = '{1, 1, 0, 0, 0};
      nk_tab = '{0, 0, 0, 1, 1};
      exp_g  = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
      do_reset();
      m_valid = 1; m_data = 8'h30; out_ready = 1;
      prev_acc = 0; beats = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (prev_acc) m_data = m_data + 8'h01;
         m_valid = mv_tab[i];
         n_valid = nk_tab[i];
         k_valid = nk_tab[i];
         #1;
         checks++;
         if (grant_sel !== exp_g[i]) begin errors++; $display("FAIL gap grant[%0d]: got %b expected %b", i, grant_sel, exp_g[i]); end
         if (i == 3) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== 8'h31) begin errors++; $display("FAIL gap drained: got valid=%b data=%h expected valid=0 data=31", out_valid, out_data); end
         end
         if (m_valid && m_ready) beats++;
         prev_acc = m_valid && m_ready;
      end
      checks++;
      if (beats != 2) begin errors++; $display("FAIL gap beats: got %0d expected 2", beats); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      n_valid = 1; n_data = 8'h40; out_ready = 0;
      @(negedge clk);
      #1;
      checks++;
      if (grant_sel !== 3'b001) begin errors++; $display("FAIL midrst grant: got %b expected 001", grant_sel); end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h40) begin errors++; $display("FAIL midrst loaded: got valid=%b data=%h expected valid=1 data=40", out_valid, out_data); end
      rst = 1;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || grant_sel !== 3'b000 || busy !== 1'b0 || out_data !== 8'h00)
      begin
         errors++;
         $display("FAIL midrst cleared: got valid=%b grant=%b busy=%b data=%h expected 0 000 0 00",
                  out_valid, grant_sel, busy, out_data);
      end
      rst = 0;
      n_valid = 1; k_valid = 1; m_valid = 1; out_ready = 1;
      @(negedge clk);
      #1;
      checks++;
      if (grant_sel !== 3'b001) begin errors++; $display("FAIL midrst pointer: got %b expected 001", grant_sel); end
      clear_inputs();
   endtask

   task automatic test_burst_one();
      logic [2:0] exp_g [8];
      logic [2:0] exp_src [8];
      logic [7:0] exp_dat [8];
      exp_g   = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
      exp_src = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
      exp_dat = '{8'h00, 8'h50, 8'h00, 8'h60, 8'h00, 8'h50, 8'h00, 8'h60};
      do_reset();
      b1_n_valid = 1; b1_k_valid = 1; b1_out_ready = 1;
      b1_n_data = 8'h50; b1_k_data = 8'h60;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (b1_grant_sel !== exp_g[i]) begin errors++; $display("FAIL burst1 grant[%0d]: got %b expected %b", i, b1_grant_sel, exp_g[i]); end
         if (i % 2 == 1) begin
            checks++;
            if (b1_out_src !== exp_src[i] || b1_out_data !== exp_dat[i] || b1_out_valid !== 1'b1)
            begin
               errors++;
               $display("FAIL burst1 beat[%0d]: got src=%b data=%h valid=%b expected src=%b data=%h valid=1",
                        i, b1_out_src, b1_out_data, b1_out_valid, exp_src[i], exp_dat[i]);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_n();
      test_contention();
      test_backpressure();
      test_gap_release();
      test_reset_mid_burst();
      test_burst_one();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
